// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port round-robin arbiter with burst allowance for a single-port data memory
module dmem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int BURST  = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              r0_req_i,
    input  logic              r0_we_i,
    input  logic [ADDR_W-1:0] r0_addr_i,
    input  logic [DATA_W-1:0] r0_wdata_i,
    output logic              r0_gnt_o,
    output logic              r0_rvalid_o,
    output logic [DATA_W-1:0] r0_rdata_o,
    input  logic              r1_req_i,
    input  logic              r1_we_i,
    input  logic [ADDR_W-1:0] r1_addr_i,
    input  logic [DATA_W-1:0] r1_wdata_i,
    output logic              r1_gnt_o,
    output logic              r1_rvalid_o,
    output logic [DATA_W-1:0] r1_rdata_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic              mem_we_o,
    output logic              mem_re_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              stall_o
);

    localparam logic [3:0] BURST_C = 4'(BURST);

    logic              last_gnt_q, last_gnt_d;
    logic [3:0]        burst_cnt_q, burst_cnt_d;
    logic              r0_rvalid_q, r1_rvalid_q;
    logic [DATA_W-1:0] r0_rdata_q, r1_rdata_q;
    logic              gnt0, gnt1, regrant;

    always_comb begin
        gnt0    = 1'b0;
        gnt1    = 1'b0;
        // A zero count only occurs out of reset, so the port opposite last_gnt wins first contention.
        regrant = (burst_cnt_q != 4'd0) && (burst_cnt_q < BURST_C);
        if (!rst_i) begin
            if (r0_req_i && r1_req_i) begin
                if (last_gnt_q) begin
                    gnt1 = regrant;
                    gnt0 = ~regrant;
                end else begin
                    gnt0 = regrant;
                    gnt1 = ~regrant;
                end
            end else begin
                gnt0 = r0_req_i;
                gnt1 = r1_req_i;
            end
        end
    end

    always_comb begin
        last_gnt_d  = last_gnt_q;
        burst_cnt_d = burst_cnt_q;
        if (gnt0 || gnt1) begin
            if (gnt1 == last_gnt_q) begin
                if (burst_cnt_q < BURST_C) begin
                    burst_cnt_d = burst_cnt_q + 4'd1;
                end
            end else begin
                last_gnt_d  = gnt1;
                burst_cnt_d = 4'd1;
            end
        end
    end

    always_comb begin
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_we_o    = 1'b0;
        mem_re_o    = 1'b0;
        if (gnt0) begin
            mem_addr_o  = r0_addr_i;
            mem_wdata_o = r0_wdata_i;
            mem_we_o    = r0_we_i;
            mem_re_o    = ~r0_we_i;
        end else if (gnt1) begin
            mem_addr_o  = r1_addr_i;
            mem_wdata_o = r1_wdata_i;
            mem_we_o    = r1_we_i;
            mem_re_o    = ~r1_we_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_gnt_q  <= 1'b1;
            burst_cnt_q <= 4'd0;
            r0_rvalid_q <= 1'b0;
            r1_rvalid_q <= 1'b0;
            r0_rdata_q  <= '0;
            r1_rdata_q  <= '0;
        end else begin
            last_gnt_q  <= last_gnt_d;
            burst_cnt_q <= burst_cnt_d;
            r0_rvalid_q <= gnt0 & ~r0_we_i;
            r1_rvalid_q <= gnt1 & ~r1_we_i;
            if (gnt0 && !r0_we_i) begin
                r0_rdata_q <= mem_rdata_i;
            end
            if (gnt1 && !r1_we_i) begin
                r1_rdata_q <= mem_rdata_i;
            end
        end
    end

    assign r0_gnt_o    = gnt0;
    assign r1_gnt_o    = gnt1;
    assign r0_rvalid_o = r0_rvalid_q;
    assign r1_rvalid_o = r1_rvalid_q;
    assign r0_rdata_o  = r0_rdata_q;
    assign r1_rdata_o  = r1_rdata_q;
    assign stall_o     = r0_req_i & ~gnt0;

endmodule
